// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU (port 0)
// and the DMA/debug loader (port 1): arbitrate, access, registered completion.
module dmem_arbiter #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int IDX_W = 5
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic          done0,
   output logic          done1,
   output logic          err0,
   output logic          err1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          mem_write,
   output logic          mem_read,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_datain,
   input  logic [DW-1:0] mem_dataout
);

   // state  | meaning
   // IDLE   | access stage empty, no memory cycle this clock
   // ACCESS | access stage holds an accepted command, memory driven this clock
   typedef enum logic {IDLE, ACCESS} state_t;

   state_t        state;
   logic          last;
   logic          st_port;
   logic          st_we;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_wdata;
   logic          accept;
   logic          range_ok;
   logic          in_access;

   // On a tie the port that did not win last time gets the grant.
   assign ack0   = ~Reset & req0 & (~req1 | last);
   assign ack1   = ~Reset & req1 & (~req0 | ~last);
   assign accept = ack0 | ack1;

   assign in_access = (state == ACCESS);
   assign range_ok  = (st_addr[AW-1:IDX_W+2] == '0);

   assign mem_addr   = st_addr;
   assign mem_datain = st_wdata;
   assign mem_write  = in_access & st_we & range_ok & ~Reset;
   assign mem_read   = in_access & ~st_we & range_ok;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         last     <= 1'b1;
         st_port  <= 1'b0;
         st_we    <= 1'b0;
         st_addr  <= '0;
         st_wdata <= '0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         err0     <= 1'b0;
         err1     <= 1'b0;
         rdata0   <= '0;
         rdata1   <= '0;
      end else begin
         state <= accept ? ACCESS : IDLE;
         if (accept) begin
            last     <= ack1;
            st_port  <= ack1;
            st_we    <= ack1 ? we1 : we0;
            st_addr  <= ack1 ? addr1 : addr0;
            st_wdata <= ack1 ? wdata1 : wdata0;
         end
         done0 <= in_access & ~st_port;
         done1 <= in_access & st_port;
         err0  <= in_access & ~st_port & ~range_ok;
         err1  <= in_access & st_port & ~range_ok;
         if (mem_read & ~st_port) rdata0 <= mem_dataout;
         if (mem_read & st_port)  rdata1 <= mem_dataout;
      end
   end

endmodule
